// File: rtl/blinker_pkg.sv
// Shared types and default constants for the blinker input-conditioning stage.
// The long-press feature is enabled with BLINKER_DEBOUNCE_LONG_PRESS_EN.
package blinker_pkg;

    // Debounce FSM: either tracking a settled level or timing a candidate change
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1000;
    localparam int DEF_LONG_CYCLES   = 500000;

endpackage

// File: rtl/blinker_sync.sv
// Multi-flop synchroniser that brings the raw button into the system1000 domain.
module blinker_sync
    import blinker_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic synced
);

    logic [STAGES-1:0] chain;

    // Shift the raw level through the chain; reset flushes it to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], raw};
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/blinker_debouncer.sv
// Push-button conditioner: synchronise, debounce, emit clean level and
// single-cycle press/release pulses. Defining BLINKER_DEBOUNCE_LONG_PRESS_EN
// adds long_o, a one-shot pulse once the level has been held high long enough.
module blinker_debouncer
    import blinker_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic system1000,
    input  logic system1000_rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
`ifdef BLINKER_DEBOUNCE_LONG_PRESS_EN
    ,
    output logic long_o
`endif
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next, press_next, release_next;

    blinker_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (system1000),
        .rst    (system1000_rst),
        .raw    (btn_i),
        .synced (s)
    );

    // Next-state: time how long s has disagreed with the accepted level
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level_o;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s != level_o) begin
                    state_next = ST_SETTLING;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            ST_SETTLING: begin
                if (s == level_o) begin
                    // bounced back before settling: drop the candidate silently
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = ST_STABLE;
                    cnt_next     = '0;
                    level_next   = s;
                    press_next   = s;
                    release_next = ~s;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, settle counter, level and pulse registers
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state     <= ST_STABLE;
            cnt       <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            level_o   <= level_next;
            press_o   <= press_next;
            release_o <= release_next;
        end
    end

`ifdef BLINKER_DEBOUNCE_LONG_PRESS_EN
    localparam int              LCNT_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_FIRE = LCNT_W'(LONG_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    logic [LCNT_W-1:0] lcnt;

    // Hold timer; saturation guarantees the LONG_CYCLES-1 match (and pulse)
    // happens once per press, LONG_CYCLES edges after press_o
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            lcnt   <= '0;
            long_o <= 1'b0;
        end else begin
            long_o <= level_o && (lcnt == LCNT_FIRE);
            if (!level_o) begin
                lcnt <= '0;
            end else if (lcnt != LCNT_MAX) begin
                lcnt <= lcnt + LCNT_ONE;
            end
        end
    end
`else
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
`endif

endmodule
